// File: rtl/sram_port_arb.sv
// Front-end for a simple dual-port SRAM: clears the array after reset or on clr, then shares
// the read and write ports among N clients with independent round-robin arbiters.
module sram_port_arb #(
    parameter int unsigned N    = 2,
    parameter int unsigned A    = 16,
    parameter int unsigned D    = 32,
    parameter int unsigned S    = 2,
    parameter int unsigned INIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    output logic           init_done,
    input  logic [N-1:0]   rd_req_valid,
    output logic [N-1:0]   rd_req_ready,
    input  logic [N*A-1:0] rd_req_addr,
    output logic [N-1:0]   rd_rsp_valid,
    output logic [D-1:0]   rd_rsp_data,
    input  logic [N-1:0]   wr_req_valid,
    output logic [N-1:0]   wr_req_ready,
    input  logic [N*A-1:0] wr_req_addr,
    input  logic [N*D-1:0] wr_req_data,
    input  logic [N*S-1:0] wr_req_strb,
    output logic           sram_ren,
    output logic [A-1:0]   sram_raddr,
    input  logic [D-1:0]   sram_rdata,
    output logic           sram_wen,
    output logic [A-1:0]   sram_waddr,
    output logic [D-1:0]   sram_wdata,
    output logic [S-1:0]   sram_wstrb
);

    localparam int unsigned PW = $clog2(N);

    typedef enum logic {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [A-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [N-1:0]    rsp_valid_q;
    logic [PW-1:0]   rd_idx, wr_idx;
    logic            rd_any, wr_any, rd_gnt, wr_gnt, run;

    // Returns {found, index} of the first request at or after ptr, wrapping modulo N.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(N);
            if (req[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        run              = (state_q == StRun);
        {rd_any, rd_idx} = rr_pick(rd_req_valid, rd_ptr_q);
        {wr_any, wr_idx} = rr_pick(wr_req_valid, wr_ptr_q);
        rd_gnt           = run && rd_any;
        wr_gnt           = run && wr_any;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = StRun;
            end
            StRun: begin
                if (clr && INIT != 0) state_d = StClear;
            end
            default: state_d = state_q;
        endcase
        if (rd_gnt) rd_ptr_d = PW'((int'(rd_idx) + 1) % int'(N));
        if (wr_gnt) wr_ptr_d = PW'((int'(wr_idx) + 1) % int'(N));
    end

    always_comb begin
        rd_req_ready = '0;
        wr_req_ready = '0;
        if (rd_gnt) rd_req_ready[rd_idx] = 1'b1;
        if (wr_gnt) wr_req_ready[wr_idx] = 1'b1;
        init_done    = run;
        sram_ren     = rd_gnt;
        sram_raddr   = rd_req_addr[int'(rd_idx)*A +: A];
        // wr_idx falls back to client 0 when nobody requests, which keeps idle pins from client 0.
        sram_wen     = !run || wr_gnt;
        sram_waddr   = run ? wr_req_addr[int'(wr_idx)*A +: A] : cnt_q;
        sram_wdata   = run ? wr_req_data[int'(wr_idx)*D +: D] : '0;
        sram_wstrb   = run ? wr_req_strb[int'(wr_idx)*S +: S] : '1;
        rd_rsp_valid = rsp_valid_q;
        rd_rsp_data  = sram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= (INIT != 0) ? StClear : StRun;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rsp_valid_q <= rd_req_ready;
        end
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Randomized bench for sram_port_arb with a behavioural SRAM and a per-cycle reference model
// of clearing, round-robin arbitration and read responses.
module tb_sram_port_arb;

    localparam int N  = 2;
    localparam int A  = 4;
    localparam int D  = 32;
    localparam int S  = 2;
    localparam int LW = D / S;
    localparam int WORDS = 1 << A;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic           init_done;
    logic [N-1:0]   rd_req_valid, rd_req_ready, rd_rsp_valid;
    logic [N*A-1:0] rd_req_addr;
    logic [D-1:0]   rd_rsp_data;
    logic [N-1:0]   wr_req_valid, wr_req_ready;
    logic [N*A-1:0] wr_req_addr;
    logic [N*D-1:0] wr_req_data;
    logic [N*S-1:0] wr_req_strb;
    logic           sram_ren, sram_wen;
    logic [A-1:0]   sram_raddr, sram_waddr;
    logic [D-1:0]   sram_rdata, sram_wdata;
    logic [S-1:0]   sram_wstrb;

    sram_port_arb #(.N(N), .A(A), .D(D), .S(S), .INIT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .init_done    (init_done),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_ready (wr_req_ready),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_req_strb  (wr_req_strb),
        .sram_ren     (sram_ren),
        .sram_raddr   (sram_raddr),
        .sram_rdata   (sram_rdata),
        .sram_wen     (sram_wen),
        .sram_waddr   (sram_waddr),
        .sram_wdata   (sram_wdata),
        .sram_wstrb   (sram_wstrb)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered read returns the pre-write contents on a same-address clash.
    logic [D-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_raddr];
        if (sram_wen) begin
            for (int l = 0; l < S; l++)
                if (sram_wstrb[l]) mem[sram_waddr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
        end
    end

    // Reference model state
    logic [D-1:0] ref_mem [WORDS];
    bit           m_clear;
    int           m_cnt, rptr, wptr, last_gr, last_gw;
    logic [N-1:0] exp_rsp_v;
    logic [D-1:0] exp_rsp_d;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_clear   = 1'b1;
        m_cnt     = 0;
        rptr      = 0;
        wptr      = 0;
        exp_rsp_v = '0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, return just after rise.
    task automatic step();
        logic [N-1:0] eg_r, eg_w;
        logic [A-1:0] wa;
        logic [D-1:0] wd;
        logic [S-1:0] ws;
        int           gr, gw;
        @(negedge clk);
        eg_r = '0;
        eg_w = '0;
        gr   = -1;
        gw   = -1;
        if (!m_clear) begin
            gr = rr(rd_req_valid, rptr);
            gw = rr(wr_req_valid, wptr);
            if (gr >= 0) eg_r[gr] = 1'b1;
            if (gw >= 0) eg_w[gw] = 1'b1;
        end
        check_eq("init_done", init_done, !m_clear);
        check_eq("rd_ready", rd_req_ready, eg_r);
        check_eq("wr_ready", wr_req_ready, eg_w);
        check_eq("sram_ren", sram_ren, gr >= 0);
        if (gr >= 0) check_eq("sram_raddr", sram_raddr, rd_req_addr[gr*A +: A]);
        check_eq("rsp_valid", rd_rsp_valid, exp_rsp_v);
        if (exp_rsp_v != 0) check_eq("rsp_data", rd_rsp_data, exp_rsp_d);
        if (m_clear) begin
            wa = A'(m_cnt); wd = '0; ws = '1;
        end else begin
            wa = wr_req_addr[(gw < 0 ? 0 : gw)*A +: A];
            wd = wr_req_data[(gw < 0 ? 0 : gw)*D +: D];
            ws = wr_req_strb[(gw < 0 ? 0 : gw)*S +: S];
        end
        check_eq("sram_wen", sram_wen, m_clear || gw >= 0);
        check_eq("sram_waddr", sram_waddr, wa);
        if (m_clear || gw >= 0) begin
            check_eq("sram_wdata", sram_wdata, wd);
            check_eq("sram_wstrb", sram_wstrb, ws);
        end
        // Advance: read sees memory before this cycle's write.
        exp_rsp_v = eg_r;
        if (gr >= 0) begin
            exp_rsp_d = ref_mem[rd_req_addr[gr*A +: A]];
            rptr      = (gr + 1) % N;
        end
        if (m_clear) begin
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == WORDS) begin
                m_clear = 1'b0;
                m_cnt   = 0;
            end
        end else begin
            if (gw >= 0) begin
                for (int l = 0; l < S; l++)
                    if (ws[l]) ref_mem[wa][l*LW +: LW] = wd[l*LW +: LW];
                wptr = (gw + 1) % N;
            end
            if (clr) m_clear = 1'b1;
        end
        last_gr = gr;
        last_gw = gw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req_valid = '0;
        wr_req_valid = '0;
        clr          = 1'b0;
    endtask

    task automatic rd(input int c, input int addr);
        rd_req_valid[c]          = 1'b1;
        rd_req_addr[c*A +: A]    = A'(addr);
    endtask

    task automatic wr(input int c, input int addr, input logic [D-1:0] data, input logic [S-1:0] st);
        wr_req_valid[c]       = 1'b1;
        wr_req_addr[c*A +: A] = A'(addr);
        wr_req_data[c*D +: D] = data;
        wr_req_strb[c*S +: S] = st;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst = 1'b1;
        idle();
        rd_req_addr = '0;
        wr_req_addr = '0;
        wr_req_data = '0;
        wr_req_strb = '0;
        model_reset();
        #1;
        check_eq("reset_rsp_valid", rd_rsp_valid, '0);
        check_eq("reset_init_done", init_done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (WORDS + 1) step();

        wr(1, 5, 32'hDEADBEEF, 2'b11); step(); idle();
        rd(0, 5); step(); idle(); step();
        check_eq("readback_beef", exp_rsp_d, 32'hDEADBEEF);
        rd(1, 5); step(); idle(); step();

        rd(0, 1); rd(1, 2); repeat (4) step(); idle(); step();

        wr(0, 3, 32'h11112222, 2'b11); rd(1, 3); step(); idle(); step();
        rd(1, 3); step(); idle(); step();

        wr(0, 5, 32'hAAAA5555, 2'b10); step(); idle();
        rd(0, 5); step(); idle(); step();
        check_eq("partial_write", exp_rsp_d, 32'hAAAABEEF);

        rd(0, 3); clr = 1'b1; step(); idle();
        repeat (WORDS + 1) step();
        rd(0, 5); step(); idle(); step();

        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!(rd_req_valid[c] && last_gr != c)) begin
                    rd_req_valid[c]       = 1'($urandom_range(0, 1));
                    rd_req_addr[c*A +: A] = A'($urandom);
                end
                if (!(wr_req_valid[c] && last_gw != c)) begin
                    wr_req_valid[c]       = 1'($urandom_range(0, 1));
                    wr_req_addr[c*A +: A] = A'($urandom);
                    wr_req_data[c*D +: D] = $urandom;
                    wr_req_strb[c*S +: S] = S'($urandom);
                end
            end
            clr = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();
        while (m_clear) step();
        step();

        clr = 1'b1; step(); idle();
        while (!(m_clear && m_cnt == 7)) step();
        @(negedge clk);
        check_eq("pre_rst_waddr", sram_waddr, 7);
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_waddr", sram_waddr, 0);
        check_eq("rst_init_done", init_done, 1'b0);
        check_eq("rst_rsp_valid", rd_rsp_valid, '0);
        @(posedge clk);
        @(posedge clk);
        ref_mem[0] = '0;
        #1 rst = 1'b0;
        repeat (WORDS + 1) step();
        rd(1, 5); step(); idle(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arb.md
Name: sram_port_arb

Overview:
- Controller sitting in front of the simple dual-port SRAM: one registered read port, one byte-strobed write port.
- Shares the read port and the write port among N requesters, each port with its own round-robin arbiter.
- After reset, and on request, it clears the whole array to zero before granting any client.
- Drives the SRAM's ren/raddr/rdata and wen/waddr/wdata/wstrb pins directly.

Parameters:
- N, 2, number of requesters (N >= 2)
- A, 16, SRAM address width
- D, 32, SRAM data width
- S, 2, write strobe lanes (D divisible by S)
- INIT, 1, 1 = clear array after reset and on clr; 0 = no clearing, RUN immediately

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  pulse: re-clear the array (ignored while clearing or when INIT=0)
- init_done  out  1  high in RUN state
- rd_req_valid  in  N  per-client read request
- rd_req_ready  out  N  per-client read grant, one-hot or zero
- rd_req_addr  in  N*A  client i address at [i*A+:A]
- rd_rsp_valid  out  N  one-hot read response strobe
- rd_rsp_data  out  D  read data, shared by all clients, qualified by rd_rsp_valid
- wr_req_valid  in  N  per-client write request
- wr_req_ready  out  N  per-client write grant, one-hot or zero
- wr_req_addr  in  N*A  client i address at [i*A+:A]
- wr_req_data  in  N*D  client i data at [i*D+:D]
- wr_req_strb  in  N*S  client i strobes at [i*S+:S]
- sram_ren  out  1  SRAM read enable
- sram_raddr  out  A  SRAM read address
- sram_rdata  in  D  SRAM registered read data, valid the cycle after sram_ren
- sram_wen  out  1  SRAM write enable
- sram_waddr  out  A  SRAM write address
- sram_wdata  out  D  SRAM write data
- sram_wstrb  out  S  SRAM write strobes

Behaviour:
- States: CLEAR, RUN.
- Reset state is CLEAR if INIT=1, RUN if INIT=0.
- Reset values: clear counter 0, both round-robin pointers 0, rd_rsp_valid 0, init_done = !INIT.
- CLEAR, per cycle:
  - sram_wen=1, sram_waddr=counter, sram_wdata=0, sram_wstrb all ones; counter increments.
  - All rd_req_ready, wr_req_ready and sram_ren are 0.
  - After writing address 2^A-1 (2^A cycles total): counter wraps to 0, state goes to RUN, init_done goes high the next cycle.
- RUN, with clr=1: state goes to CLEAR next cycle.
  - The clr cycle itself still arbitrates normally.
  - A read granted in that cycle still returns its response in the first CLEAR cycle.
- Read arbiter (RUN):
  - Grant g is the first asserted rd_req_valid at or after the read pointer, wrapping modulo N.
  - rd_req_ready = onehot(g), combinational.
  - sram_ren=1 and sram_raddr = client g address, in the same cycle.
  - On grant, the pointer becomes (g+1) mod N.
  - No request means no grant and the pointer holds.
- Read response:
  - rd_rsp_valid = the grant vector registered one cycle; rd_rsp_data = sram_rdata.
  - Latency: request accepted in cycle t, response in cycle t+1.
  - Throughput: one read per cycle.
- Write arbiter: independent of the read arbiter, same round-robin rule.
  - Granted client's addr/data/strb are muxed to the sram_w* pins, sram_wen=1.
  - A grant with all-zero strobes is still a grant; the SRAM leaves memory unchanged.
- Read and write may both be granted in the same cycle.
  - Same address in that cycle: the read returns the pre-write data. No forwarding.
- When no write is granted in RUN: sram_wen=0; sram_waddr/wdata/wstrb are don't-care but driven from client 0.
- Reset during CLEAR restarts the clear from address 0.
- Reset drops any in-flight response (rd_rsp_valid=0).
- Requests held while not granted must keep their payload stable; the arbiter does not latch payloads.

Test Plan (N=2, A=4, D=32, S=2, INIT=1):
- Release rst, no requests:
  - 16 cycles of sram_wen=1, waddr 0..15, wdata 0, wstrb 2'b11, all readies 0.
  - init_done=1 on cycle 17.
- After init, client 1 writes 0xDEADBEEF to addr 5 (strb 11); then client 0 reads addr 5:
  - rd_rsp_valid=2'b01 one cycle after the grant, rd_rsp_data=0xDEADBEEF.
- Both clients hold rd_req_valid for 4 cycles:
  - grants alternate 01,10,01,10 (pointer reset to 0).
  - Responses follow, each one cycle later.
- Same cycle: client 0 writes 0x11112222 to addr 3, client 1 reads addr 3 (previously 0):
  - the read returns 0; a re-read returns 0x11112222.
- Partial write: strb 2'b10, data 0xAAAA5555 to addr 5 (holding 0xDEADBEEF) -> readback 0xAAAABEEF.
- clr pulse in RUN while client 0 reads:
  - that read's response is delivered.
  - Then 16 clear cycles with readies 0, init_done low during the clear.
  - A later read of addr 5 returns 0.
  - rst asserted at clear address 7 restarts the clear at 0.
